// File: rtl/pipeline_pkg.sv
// Shared pipeline types and defaults for the MIPS five-stage pipeline.
package pipeline_pkg;

  typedef logic [31:0] word_t;

  // PC value after reset and the bubble instruction (sll $0,$0,0).
  localparam word_t RESET_PC  = 32'h0000_0000;
  localparam word_t NOP_INSTR = 32'h0000_0000;

  // Fetch FSM: START idles one cycle after reset, FETCH has a request for pc
  // outstanding, KILL drains an access that a redirect made wrong-path.
  typedef enum logic [1:0] {
    START = 2'd0,
    FETCH = 2'd1,
    KILL  = 2'd2
  } if_state_t;

  // Sequential successor of a word address; wraps modulo 2^32.
  function automatic word_t nextSeqPc(input word_t pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with hold, load and flush-to-bubble controls.
// Priority: flush > hold > load > bubble. A bubble keeps pc4 and marks the
// slot invalid with a NOP in the instruction field.
module if_id_reg
  import pipeline_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] pc4Next,
  input  logic [31:0] instrNext,
  output logic [31:0] pc4,
  output logic [31:0] instr,
  output logic        valid
);

  // Register update: flush wins, stall freezes, otherwise load or insert a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc4   <= 32'h0;
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (!hold) begin
      if (load) begin
        pc4   <= pc4Next;
        instr <= instrNext;
        valid <= 1'b1;
      end else begin
        instr <= NOP_INSTR;
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory request
// port and loads the IF/ID register. Redirect priority is epc_ctrl, then
// stall, then jump/branch, then sequential PC+4.
// Optional build macro DEBUG_IF_EN adds debug_if_pc, debug_fetch_count and
// debug_squash_count outputs.
module if_stage
  import pipeline_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        shouldStall,
  input  logic        shouldJumpOrBranch,
  input  logic [31:0] jumpOrBranchPc,
  input  logic        epc_ctrl,
  input  logic [31:0] jumpAddressExcept,
  input  logic        exceptClear,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_4,
  output logic [31:0] instruction,
  output logic        if_valid,
  output logic        fetchWaiting
`ifdef DEBUG_IF_EN
  ,
  output logic [31:0] debug_if_pc,
  output logic [31:0] debug_fetch_count,
  output logic [31:0] debug_squash_count
`endif
);

  if_state_t stateReg, stateNext;
  word_t     pcReg, pcNext;
  word_t     pendPcReg, pendPcNext;
  word_t     seqPc;
  word_t     redirectPc;
  logic      redirect;
  logic      holdAll;
  logic      regHold, regLoad, regFlush;
  logic      squashWord;

  // A stall freezes everything unless an exception/eret overrides it; a
  // branch under stall is dropped because ID re-evaluates it next cycle.
  assign holdAll    = shouldStall & ~epc_ctrl;
  assign redirect   = epc_ctrl | (shouldJumpOrBranch & ~shouldStall);
  assign redirectPc = epc_ctrl ? jumpAddressExcept : jumpOrBranchPc;
  assign seqPc      = nextSeqPc(pcReg);

  // In KILL the pc still holds the abandoned address, so the bus stays stable.
  assign imem_req     = (stateReg != START);
  assign imem_addr    = pcReg;
  assign fetchWaiting = imem_req & ~imem_ready;

  // Next-state, PC and IF/ID control decode.
  always_comb begin
    stateNext  = stateReg;
    pcNext     = pcReg;
    pendPcNext = pendPcReg;
    regHold    = 1'b0;
    regLoad    = 1'b0;
    regFlush   = exceptClear;
    squashWord = 1'b0;
    case (stateReg)
      START: stateNext = FETCH;
      FETCH: begin
        if (redirect) begin
          if (imem_ready) begin
            pcNext     = redirectPc;
            squashWord = 1'b1;
          end else begin
            stateNext  = KILL;
            pendPcNext = redirectPc;
          end
        end else if (holdAll) begin
          regHold = 1'b1;
        end else if (imem_ready) begin
          pcNext     = seqPc;
          regLoad    = 1'b1;
          squashWord = exceptClear;
        end
      end
      KILL: begin
        if (redirect) begin
          pendPcNext = redirectPc;
          if (imem_ready) begin
            stateNext  = FETCH;
            pcNext     = redirectPc;
            squashWord = 1'b1;
          end
        end else if (holdAll) begin
          regHold = 1'b1;
        end else if (imem_ready) begin
          stateNext  = FETCH;
          pcNext     = pendPcReg;
          squashWord = 1'b1;
        end
      end
      default: stateNext = START;
    endcase
  end

  // FSM, PC and pending-target registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateReg  <= START;
      pcReg     <= RESET_PC;
      pendPcReg <= 32'h0;
    end else begin
      stateReg  <= stateNext;
      pcReg     <= pcNext;
      pendPcReg <= pendPcNext;
    end
  end

  if_id_reg u_if_id_reg (
    .clk       (clk),
    .rst       (rst),
    .hold      (regHold),
    .load      (regLoad),
    .flush     (regFlush),
    .pc4Next   (seqPc),
    .instrNext (imem_rdata),
    .pc4       (pc_4),
    .instr     (instruction),
    .valid     (if_valid)
  );

`ifdef DEBUG_IF_EN
  word_t fetchCountReg, squashCountReg;

  // Count words latched valid and words discarded as wrong-path or killed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetchCountReg  <= 32'h0;
      squashCountReg <= 32'h0;
    end else begin
      if (regLoad & ~regFlush) fetchCountReg <= fetchCountReg + 32'd1;
      if (squashWord) squashCountReg <= squashCountReg + 32'd1;
    end
  end

  assign debug_if_pc        = pcReg;
  assign debug_fetch_count  = fetchCountReg;
  assign debug_squash_count = squashCountReg;
`endif

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage pipelined MIPS CPU. It owns the program counter and drives the instruction-memory request port. It loads the IF/ID pipeline register with `pc_4` and `instruction` for the decode stage. It consumes the decode stage's redirect, stall and exception outputs, so it is the fetch-side end of the IF↔ID interface.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value after reset.
- `NOP_INSTR`, 32'h0000_0000, bubble instruction (`sll $0,$0,0`) loaded on squash or flush.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `shouldStall`  in  1  load-use stall from ID; hold PC and IF/ID.
- `shouldJumpOrBranch`  in  1  taken jump or branch resolved in ID.
- `jumpOrBranchPc`  in  32  redirect target from ID.
- `epc_ctrl`  in  1  exception or eret redirect from cp0.
- `jumpAddressExcept`  in  32  exception/eret target.
- `exceptClear`  in  1  flush IF/ID to a bubble.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch word address (byte address, [1:0]=0).
- `imem_ready`  in  1  read data valid this cycle; may be high in the same cycle as `imem_req`.
- `imem_rdata`  in  32  instruction word.
- `pc_4`  out  32  IF/ID register: fetched PC+4.
- `instruction`  out  32  IF/ID register: fetched word.
- `if_valid`  out  1  IF/ID holds a real instruction.
- `fetchWaiting`  out  1  `imem_req & ~imem_ready`.

## Operation
- FSM states:
  - START: one cycle after reset release, `imem_req`=0.
  - FETCH: request for `pc` outstanding.
  - KILL: redirect arrived while a request was unacknowledged. The returning word is discarded.
- START → FETCH unconditionally.
- FETCH, redirect with `imem_ready`=0 → KILL. The target is latched in `pend_pc`.
- KILL, `imem_ready`=1 → FETCH with `pc<=pend_pc`.
- Request rule: `imem_addr`=`pc` in FETCH and `pend_pc`'s predecessor (old `pc`) in KILL. Address is stable while `imem_req & ~imem_ready`. `imem_req`=1 in FETCH and KILL.
- Redirect priority, highest first:
  1. `epc_ctrl` (target `jumpAddressExcept`).
  2. `shouldStall`. A branch under stall is ignored, because ID re-evaluates it next cycle.
  3. `shouldJumpOrBranch` (target `jumpOrBranchPc`).
  4. Sequential `pc+4`.
- No delay slot. On a taken redirect, the word fetched in that cycle is wrong-path: IF/ID ← `NOP_INSTR`, `if_valid`=0.
- FETCH with `imem_ready`=1, no stall, no redirect: `pc<=pc+4`, `pc_4<=pc+4`, `instruction<=imem_rdata`, `if_valid<=1`.
- FETCH with `imem_ready`=0, no stall: IF/ID ← bubble, so downstream keeps moving. PC unchanged.
- `shouldStall`=1, no `epc_ctrl`/`exceptClear`: PC, IF/ID and the FSM hold. The request stays asserted with the same address, because a re-read is idempotent and needs no skid buffer.
- `exceptClear`=1: IF/ID ← bubble regardless of stall or ready.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- Reset values (async on `rst`=0):
  - `pc`=`RESET_PC`, state START, `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `pc_4`=0, `instruction`=`NOP_INSTR`, `if_valid`=0, `fetchWaiting`=0, `pend_pc`=0.
- First request is in the 2nd cycle after `rst` rises.
- Fetch latency with zero-wait memory is 1 cycle: address in cycle N, IF/ID valid after edge N.
- Throughput with zero-wait memory is 1 instruction/cycle.
- A redirect asserted in cycle N makes the target address visible in cycle N+1 if ready, or after the killed access completes otherwise.
- Redirect and `exceptClear` are sampled combinationally from ID/cp0 in the same cycle; no extra register.
- Reset mid-request drops the request immediately. Memory must tolerate an abandoned access.

## Configuration
- `DEBUG_IF_EN` defined: adds the following outputs.
  - `debug_if_pc` [31:0]: current `pc`.
  - `debug_fetch_count` [31:0]: increments on each word latched valid.
  - `debug_squash_count` [31:0]: increments on each wrong-path or killed word.
  - Both counters reset to 0 and wrap.
- `DEBUG_IF_EN` undefined: ports and counters are absent. Functional behaviour is identical.

## Structure
- Shared package `pipeline_pkg`:
  - `NOP_INSTR` and `RESET_PC` defaults.
  - `if_state_t` enum {START, FETCH, KILL}.
  - 32-bit `word_t` typedef.
- Sub-module `if_id_reg`: the IF/ID register with hold (stall), load and flush-to-bubble controls. It is reused by the later ID/EX register refactor.
- `if_stage` keeps the PC, `pend_pc`, FSM and priority logic.

## Test plan
- Reset release, zero-wait memory returning `addr` as data → `imem_addr` 0,4,8,… on consecutive cycles; `pc_4`=4,8,12; `if_valid`=1 from the 2nd fetch edge.
- `shouldJumpOrBranch`=1 with target 0x40 at `pc`=0x8 → IF/ID bubble; next `imem_addr`=0x40; word from 0x8 never appears valid.
- `shouldStall`=1 for 3 cycles at `pc`=0x10 → `imem_addr` stays 0x10; `pc_4`/`instruction` unchanged; resumes at 0x14 afterward.
- Memory with 2 wait states, branch to 0x80 during the first wait cycle → state KILL; returning word discarded (`if_valid`=0); next request 0x80; `debug_squash_count`+1.
- `epc_ctrl`=1 (target 0x8000_0180) together with `shouldStall`=1 and `shouldJumpOrBranch`=1 → `pc` becomes 0x8000_0180; IF/ID bubble.
- `rst` asserted while `imem_req`=1 → same-cycle `imem_req`=0, `instruction`=`NOP_INSTR`; restart from `RESET_PC`.
